// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI mode-0 slave fronting N_REGS 8-bit registers, clocked by sclk.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso while cs_n is high.
module spi_slave_param #(
    parameter int         N_REGS    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'h7E,
    parameter logic [7:0] READ_TAG  = 8'h88
) (
    input  logic sclk,
    input  logic rst,
    input  logic cs_n,
    input  logic mosi,
    output logic miso
);
    localparam int PW = $clog2(N_REGS + 1);
    localparam logic [2:0] SYNC1 = 3'd0, SYNC2 = 3'd1, TAG = 3'd2, DATA = 3'd3, READ = 3'd4;
    logic [2:0]    state, cnt;
    logic [6:0]    sh, osh;
    logic [7:0]    tag, rx, rd;
    logic [PW-1:0] rptr;
    logic          done, miso_r;
    logic [7:0]    regs [0:N_REGS-1];
    assign rx   = {sh, mosi};
    assign done = cnt == 3'd7;
    always_comb begin
        rd = '0;
        for (int i = 0; i < N_REGS; i++) rd = (rptr == PW'(i)) ? regs[i] : rd;
    end
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state <= SYNC1;
            cnt   <= '0;
            sh    <= '0;
            tag   <= '0;
            rptr  <= '0;
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (cs_n) begin
            state <= SYNC1;
            cnt   <= '0;
            rptr  <= '0;
        end else begin
            cnt <= cnt + 3'd1;
            sh  <= rx[6:0];
            if (done)
                case (state)
                    SYNC1: state <= (rx == SYNC_BYTE) ? SYNC2 : SYNC1;
                    SYNC2: state <= (rx == SYNC_BYTE) ? TAG : SYNC1;
                    TAG: begin
                        tag   <= rx;
                        state <= DATA;
                    end
                    DATA: begin
                        for (int i = 0; i < N_REGS; i++)
                            if (tag == 8'(i)) regs[i] <= rx;
                        rptr  <= '0;
                        state <= (tag == READ_TAG) ? READ : SYNC1;
                    end
                    READ: begin
                        rptr  <= rptr + PW'(1);
                        state <= (rptr == PW'(N_REGS - 1)) ? SYNC1 : READ;
                    end
                    default: state <= SYNC1;
                endcase
        end
    end
    // A fresh register snapshot is taken on the falling edge right after each byte boundary.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            osh    <= '0;
            miso_r <= 1'b0;
        end else if (state != READ) begin
            osh    <= '0;
            miso_r <= 1'b0;
        end else if (cnt == 3'd0) begin
            osh    <= rd[6:0];
            miso_r <= rd[7];
        end else begin
            osh    <= {osh[5:0], 1'b0};
            miso_r <= osh[6];
        end
    end
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = cs_n ? 1'bz : miso_r;
`else
    assign miso = miso_r;
`endif
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: scoreboard bench; driver queues expected readback bytes, monitor compares.
module tb_spi_slave_param;
    logic sclk = 1'b0;
    logic rst, cs_n, mosi, miso, cap;
    logic [7:0] model [0:7];
    logic [7:0] q [$];
    logic [7:0] acc, exp_b;
    int checks = 0, errors = 0, nb = 0;

    spi_slave_param dut (.sclk(sclk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso));

    always #5 sclk = ~sclk;

    always @(posedge sclk) begin
        if (cap) begin
            acc = {acc[6:0], miso};
            nb++;
            if (nb == 8) begin
                nb = 0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL readback: got %02h, no byte expected", acc);
                end else begin
                    exp_b = q.pop_front();
                    if (acc !== exp_b) begin
                        errors++;
                        $display("FAIL readback: got %02h, expected %02h", acc, exp_b);
                    end
                end
            end
        end else nb = 0;
    end

    task automatic send(input logic [7:0] b, input int n, input logic c);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge sclk);
            cs_n = 1'b0;
            mosi = b[i];
            cap  = c;
        end
    endtask

    task automatic cs_hi(input int n);
        @(negedge sclk);
        cs_n = 1'b1;
        mosi = 1'b0;
        cap  = 1'b0;
        repeat (n) @(negedge sclk);
    endtask

    task automatic wr(input logic [7:0] t, input logic [7:0] d);
        send(8'h7E, 8, 1'b0);
        send(8'h7E, 8, 1'b0);
        send(t, 8, 1'b0);
        send(d, 8, 1'b0);
        if (t < 8'd8) model[t[2:0]] = d;
    endtask

    task automatic read_all();
        send(8'h7E, 8, 1'b0);
        send(8'h7E, 8, 1'b0);
        send(8'h88, 8, 1'b0);
        send(8'h00, 8, 1'b0);
        for (int j = 0; j < 8; j++) begin
            q.push_back(model[j]);
            send(8'h00, 8, 1'b1);
        end
        cs_hi(20);
    endtask

    task automatic check_bit(input string name, input logic want);
        checks++;
        if (miso !== want) begin
            errors++;
            $display("FAIL %s: miso=%b expected %b", name, miso, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1; cs_n = 1'b1; mosi = 1'b0; cap = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        #1;
        check_bit("reset_miso", 1'b0);
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        cs_hi(4);
        read_all();
        for (int i = 0; i < 8; i++) begin
            v = 8'h11 << i;
            wr(8'(i), v);
            cs_hi(20);
        end
        read_all();
        send(8'h7E, 8, 1'b0);
        send(8'h55, 8, 1'b0);
        send(8'h03, 8, 1'b0);
        send(8'hAA, 8, 1'b0);
        cs_hi(20);
        send(8'h55, 8, 1'b0);
        wr(8'h02, 8'h5A);
        cs_hi(20);
        read_all();
        wr(8'h40, 8'hFF);
        cs_hi(20);
        read_all();
        send(8'h7E, 8, 1'b0);
        send(8'h7E, 8, 1'b0);
        send(8'h01, 8, 1'b0);
        send(8'hFF, 4, 1'b0);
        cs_hi(20);
        read_all();
        wr(8'h01, 8'h3C);
        cs_hi(20);
        read_all();
        wr(8'h05, 8'hA5);
        read_all();
        send(8'h7E, 8, 1'b0);
        send(8'h7E, 8, 1'b0);
        send(8'h88, 8, 1'b0);
        send(8'h00, 8, 1'b0);
        for (int j = 0; j < 2; j++) begin
            q.push_back(model[j]);
            send(8'h00, 8, 1'b1);
        end
        send(8'h00, 1, 1'b0);
        @(negedge sclk);
        #1;
        check_bit("mid_read_bit6", model[2][6]);
        rst = 1'b1;
        #1;
        check_bit("async_reset_miso", 1'b0);
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        cs_hi(3);
        rst = 1'b0;
        cs_hi(4);
        read_all();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
